// File: rtl/btn_press_counter_pkg.sv
// ============================================================================
// Module      : btn_press_counter_pkg
// Description : Shared state encoding and default parameters for the
//               pushbutton press counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_press_counter_pkg;

  localparam int unsigned C_DEBOUNCE_COUNT_DEFAULT = 1_000_000;
  localparam int unsigned C_LED_WIDTH_DEFAULT      = 16;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = S_IDLE,
    ST_PRESS_WAIT   = S_PRESS_WAIT,
    ST_PRESSED      = S_PRESSED,
    ST_RELEASE_WAIT = S_RELEASE_WAIT
  } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser plus press/release debounce FSM that
//               emits one registered pulse per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import btn_press_counter_pkg::*;
#(
  parameter int unsigned C_DEBOUNCE_COUNT = C_DEBOUNCE_COUNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse,
  output logic press_accept
);

  localparam int unsigned CNT_W    = $clog2(C_DEBOUNCE_COUNT + 1);
  localparam int unsigned ONE_INT  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = C_DEBOUNCE_COUNT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = ONE_INT[CNT_W-1:0];

  logic             sync1_q;
  logic             btn_sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_pulse_q, press_pulse_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      btn_sync_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      press_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= btn_raw;
      btn_sync_q    <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_pulse_q <= press_pulse_d;
    end
  end

  // A low sample always wins over the terminal count, so a fall on the
  // accepting edge is still treated as a bounce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_sync_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_sync_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    press_pulse_d = accept;
  end

  assign press_pulse  = press_pulse_q;
  assign press_accept = accept;

endmodule

`default_nettype wire

// File: rtl/btn_press_counter.sv
// ============================================================================
// Module      : btn_press_counter
// Description : Debounced pushbutton press counter; the tally wraps modulo
//               2^C_LED_WIDTH and is driven onto led.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_press_counter
  import btn_press_counter_pkg::*;
#(
  parameter int unsigned C_DEBOUNCE_COUNT = C_DEBOUNCE_COUNT_DEFAULT,
  parameter int unsigned C_LED_WIDTH      = C_LED_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   btnC,
  input  logic                   btnU,
  output logic                   press_pulse,
  output logic [C_LED_WIDTH-1:0] led
);

  logic                   press_accept;
  logic [C_LED_WIDTH-1:0] led_q, led_d;

  btn_debounce #(
    .C_DEBOUNCE_COUNT(C_DEBOUNCE_COUNT)
  ) btn_debounce_DUT (
    .clk          (clk),
    .rst          (btnC),
    .btn_raw      (btnU),
    .press_pulse  (press_pulse),
    .press_accept (press_accept)
  );

  // The accept strobe is taken on the same edge as the pulse register so
  // led and press_pulse change together.
  always_comb begin
    led_d = led_q;
    if (press_accept) begin
      led_d = led_q + C_LED_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

`default_nettype wire
